// File: rtl/fifo_pkt_pkg.sv
// Shared types and helpers for the FIFO packet reader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fifo_pkt_pkg;

    // Default width of the payload-length field carried in header bits [LEN_W-1:0].
    localparam int unsigned LEN_W_DEF = 8;

    // Widest data word the length helper accepts; callers zero-extend into it.
    localparam int unsigned HDR_MAX_W = 64;

    typedef enum logic {
        HDR     = 1'b0,
        PAYLOAD = 1'b1
    } pkt_state_e;

    // Returns the header word with everything above the length field cleared.
    // Callers truncate the result down to their own length width.
    function automatic logic [HDR_MAX_W-1:0] hdr_len(input logic [HDR_MAX_W-1:0] word,
                                                     input int unsigned           len_w);
        logic [HDR_MAX_W-1:0] mask;
        mask = {HDR_MAX_W{1'b1}} >> (HDR_MAX_W - len_w);
        return word & mask;
    endfunction

endpackage

// File: rtl/fifo_pkt_skid.sv
// 2-entry output buffer between the FIFO read data and the downstream consumer.
// Latency: a pushed word is visible at the head the cycle after the push.
// Backpressure: head holds while out_rdy_i is low; upstream must not push into a full buffer.
//
// Ports:
//   clk_i, rst_i          clock, asynchronous active-high reset
//   in_vld_i, in_dat_i    push strobe and word (no ready; caller tracks space via occ_o)
//   out_vld_o, out_dat_o  head-of-buffer word
//   out_rdy_i             consumer pops the head when out_vld_o is high
//   occ_o                 number of words held (0..2)
module fifo_pkt_skid
    import fifo_pkt_pkg::*;
#(
    parameter int unsigned W = 32
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         in_vld_i,
    input  logic [W-1:0] in_dat_i,
    output logic         out_vld_o,
    input  logic         out_rdy_i,
    output logic [W-1:0] out_dat_o,
    output logic [1:0]   occ_o
);

    // ent0 is always the head; ent1 only holds data when two words are buffered.
    logic [W-1:0] ent0_q, ent0_d;
    logic [W-1:0] ent1_q, ent1_d;
    logic [1:0]   occ_q, occ_d;
    logic         pop;

    assign pop = out_rdy_i & (occ_q != 2'd0);

    always_comb begin
        ent0_d = ent0_q;
        ent1_d = ent1_q;
        occ_d  = occ_q;
        case ({in_vld_i, pop})
            2'b10: begin
                if (occ_q == 2'd0) begin
                    ent0_d = in_dat_i;
                end else begin
                    ent1_d = in_dat_i;
                end
                occ_d = occ_q + 2'd1;
            end
            2'b01: begin
                ent0_d = ent1_q;
                occ_d  = occ_q - 2'd1;
            end
            2'b11: begin
                // Push and pop together: occupancy unchanged, new word lands behind the survivor.
                if (occ_q == 2'd1) begin
                    ent0_d = in_dat_i;
                end else begin
                    ent0_d = ent1_q;
                    ent1_d = in_dat_i;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ent0_q <= '0;
            ent1_q <= '0;
            occ_q  <= 2'd0;
        end else begin
            ent0_q <= ent0_d;
            ent1_q <= ent1_d;
            occ_q  <= occ_d;
        end
    end

    assign out_vld_o = (occ_q != 2'd0);
    assign out_dat_o = ent0_q;
    assign occ_o     = occ_q;

    a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
        !(in_vld_i && !pop && (occ_q == 2'd2)));

endmodule

// File: rtl/fifo_pkt_reader.sv
// Drains the address-decoder FIFO and streams words downstream with sop/eop framing.
// Latency: first word appears 2 cycles after its fifo_rd_en; 1 word/cycle sustained.
// Backpressure: out_ready low stalls the head word; reads stop once buffer + in-flight fill 2 slots.
//
// Ports:
//   clk, rst                         clock, asynchronous active-high reset
//   enable                           permits new FIFO reads
//   fifo_empty, fifo_data            FIFO read side (data valid 1 cycle after fifo_rd_en)
//   fifo_rd_en, fifo_en              FIFO pop strobe, FIFO enable (enable | busy)
//   out_valid, out_ready, out_data   downstream valid/ready word stream
//   out_sop, out_eop                 framing of the current out_data word
//   busy                             packet open, read in flight, or words buffered
module fifo_pkt_reader
    import fifo_pkt_pkg::*;
#(
    parameter int unsigned W_WIDTH = 32,
    parameter int unsigned LEN_W   = LEN_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic               fifo_empty,
    input  logic [W_WIDTH-1:0] fifo_data,
    output logic               fifo_rd_en,
    output logic               fifo_en,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [W_WIDTH-1:0] out_data,
    output logic               out_sop,
    output logic               out_eop,
    output logic               busy
);

    logic             inflight_q, inflight_d;
    pkt_state_e       state_q, state_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic [1:0]       occ;
    logic             xfer;
    logic [2:0]       slots_used;
    logic [LEN_W-1:0] hdr_n;
    logic             sop_c, eop_c;

    fifo_pkt_skid #(.W(W_WIDTH)) u_skid (
        .clk_i     (clk),
        .rst_i     (rst),
        .in_vld_i  (inflight_q),
        .in_dat_i  (fifo_data),
        .out_vld_o (out_valid),
        .out_rdy_i (out_ready),
        .out_dat_o (out_data),
        .occ_o     (occ)
    );

    assign xfer = out_valid & out_ready;

    // A word leaving this cycle frees its slot, so reads keep flowing at full rate.
    // xfer implies occ >= 1, so the subtraction cannot underflow.
    assign slots_used = 3'(occ) + 3'(inflight_q) - 3'(xfer);

    // Gated by rst so no pop is issued while the block is held in reset.
    assign fifo_rd_en = ~rst & enable & ~fifo_empty & (slots_used < 3'd2);
    assign inflight_d = fifo_rd_en;

    assign hdr_n = LEN_W'(hdr_len(HDR_MAX_W'(out_data), LEN_W));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight_q <= 1'b0;
            state_q    <= HDR;
            rem_q      <= '0;
        end else begin
            inflight_q <= inflight_d;
            state_q    <= state_d;
            rem_q      <= rem_d;
        end
    end

    // Framing applies to the head-of-buffer word and only moves on a transfer,
    // so sop/eop stay stable while the consumer stalls.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        sop_c   = 1'b0;
        eop_c   = 1'b0;
        case (state_q)
            HDR: begin
                sop_c = out_valid;
                eop_c = out_valid & (hdr_n == '0);
                if (xfer && (hdr_n != '0)) begin
                    rem_d   = hdr_n;
                    state_d = PAYLOAD;
                end
            end
            PAYLOAD: begin
                eop_c = out_valid & (rem_q == LEN_W'(1));
                if (xfer) begin
                    rem_d = rem_q - LEN_W'(1);
                    if (rem_q == LEN_W'(1)) begin
                        state_d = HDR;
                    end
                end
            end
            default: begin
                state_d = HDR;
            end
        endcase
    end

    assign out_sop = sop_c;
    assign out_eop = eop_c;
    assign busy    = (state_q == PAYLOAD) | inflight_q | out_valid;
    assign fifo_en = enable | busy;

endmodule

// File: tb/tb_fifo_pkt_reader.sv
module tb_fifo_pkt_reader;

    localparam int W = 32;

    logic         clk;
    logic         rst;
    logic         enable;
    logic         fifo_empty;
    logic [W-1:0] fifo_data = '0;
    logic         fifo_rd_en;
    logic         fifo_en;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         out_sop;
    logic         out_eop;
    logic         busy;

    fifo_pkt_reader #(.W_WIDTH(32), .LEN_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_rd_en (fifo_rd_en),
        .fifo_en    (fifo_en),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_sop    (out_sop),
        .out_eop    (out_eop),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Source FIFO: read data appears the cycle after the pop strobe.
    logic [W-1:0] mem [0:1023];
    int wr_ptr = 0;
    int rd_ptr = 0;
    assign fifo_empty = (rd_ptr == wr_ptr);
    always @(posedge clk) begin
        if (fifo_rd_en) begin
            fifo_data <= mem[rd_ptr[9:0]];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    // Transfer log, sampled on the falling edge.
    typedef struct {
        logic [W-1:0] dat;
        logic         sop;
        logic         eop;
        int           cyc;
    } xfer_t;
    xfer_t log_q[$];
    int cyc = 0;
    int first_rd = -1;
    int first_vld = -1;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (out_valid && out_ready) log_q.push_back('{out_data, out_sop, out_eop, cyc});
        if (fifo_rd_en && first_rd < 0) first_rd = cyc;
        if (out_valid && first_vld < 0) first_vld = cyc;
    end

    // Vector table: word pushed into the FIFO and the framing expected when it emerges.
    typedef struct {
        int           scn;
        int           phase;
        logic [W-1:0] word;
        logic         exp;
        logic         sop;
        logic         eop;
    } vec_t;
    vec_t vecs[$];

    int n_checks = 0;
    int n_errs = 0;

    task automatic add(input int s, input int p, input logic [W-1:0] w,
                       input logic e, input logic so, input logic eo);
        vecs.push_back('{s, p, w, e, so, eo});
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [W-1:0] w);
        mem[wr_ptr[9:0]] = w;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic push_scn(input int s, input int p);
        foreach (vecs[i]) begin
            if (vecs[i].scn == s && vecs[i].phase == p) push_word(vecs[i].word);
        end
    endtask

    task automatic check_scn(input int s, input int base);
        int k;
        k = base;
        foreach (vecs[i]) begin
            if (vecs[i].scn == s && vecs[i].exp) begin
                if (k < log_q.size()) begin
                    chk($sformatf("s%0d xfer%0d {sop,eop,data}", s, k - base),
                        {30'd0, log_q[k].sop, log_q[k].eop, log_q[k].dat},
                        {30'd0, vecs[i].sop, vecs[i].eop, vecs[i].word});
                end else begin
                    chk($sformatf("s%0d xfer%0d present", s, k - base), 64'd0, 64'd1);
                end
                k++;
            end
        end
        chk($sformatf("s%0d transfer count", s), 64'(log_q.size() - base), 64'(k - base));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int rd0;
        int bad;
        rst       = 1'b0;
        enable    = 1'b0;
        out_ready = 1'b0;

        add(0, 0, 32'h0000_0002, 1, 1, 0);
        add(0, 0, 32'h0000_00A1, 1, 0, 0);
        add(0, 0, 32'h0000_00A2, 1, 0, 1);
        add(1, 0, 32'h0000_0000, 1, 1, 1);
        add(1, 0, 32'h0000_0001, 1, 1, 0);
        add(1, 0, 32'h0000_00B1, 1, 0, 1);
        add(2, 0, 32'h0000_0004, 1, 1, 0);
        add(2, 0, 32'h0000_00C1, 1, 0, 0);
        add(2, 0, 32'h0000_00C2, 1, 0, 0);
        add(2, 0, 32'h0000_00C3, 1, 0, 0);
        add(2, 0, 32'h0000_00C4, 1, 0, 1);
        add(3, 0, 32'h0000_0003, 1, 1, 0);
        add(3, 1, 32'h0000_00D1, 1, 0, 0);
        add(3, 1, 32'h0000_00D2, 1, 0, 0);
        add(3, 1, 32'h0000_00D3, 1, 0, 1);
        add(4, 0, 32'h1234_5601, 1, 1, 0);
        add(4, 0, 32'h0000_00E1, 1, 0, 1);
        add(4, 1, 32'hEEEE_0000, 1, 1, 1);
        add(5, 0, 32'h0000_0003, 1, 1, 0);
        add(5, 0, 32'h0000_00F1, 0, 0, 0);
        add(5, 0, 32'h0000_00F2, 0, 0, 0);
        add(5, 1, 32'h0000_0001, 1, 1, 0);
        add(5, 1, 32'h0000_00C7, 1, 0, 1);

        // Reset state
        #1 rst = 1'b1;
        #3;
        chk("reset {rd_en,valid,sop,eop,busy}",
            {59'd0, fifo_rd_en, out_valid, out_sop, out_eop, busy}, 64'd0);
        chk("reset out_data", 64'(out_data), 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        step(1);
        chk("idle busy", 64'(busy), 64'd0);

        // Back-to-back packet with full-rate consumer
        enable    = 1'b1;
        out_ready = 1'b1;
        base = log_q.size();
        push_scn(0, 0);
        step(10);
        check_scn(0, base);
        chk("first valid after first rd_en", 64'(first_vld - first_rd), 64'd2);
        if (log_q.size() >= base + 3)
            chk("s0 three consecutive cycles", 64'(log_q[base+2].cyc - log_q[base].cyc), 64'd2);
        else
            chk("s0 three transfers seen", 64'(log_q.size() - base), 64'd3);
        chk("s0 busy after drain", 64'(busy), 64'd0);

        // Header-only packet then 1-word packet
        base = log_q.size();
        push_scn(1, 0);
        step(10);
        check_scn(1, base);

        // Backpressure for 5 cycles right after the header
        base = log_q.size();
        rd0  = rd_ptr;
        push_scn(2, 0);
        for (int i = 0; i < 20 && log_q.size() == base; i++) step(1);
        chk("s2 header seen before stall", 64'(log_q.size() - base), 64'd1);
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("s2 stall%0d {valid,data}", i), {31'd0, out_valid, out_data},
                {31'd0, 1'b1, 32'h0000_00C1});
        end
        chk("s2 words read during stall", 64'(rd_ptr - rd0), 64'd3);
        chk("s2 rd_en idle with full buffer", 64'(fifo_rd_en), 64'd0);
        @(posedge clk);
        #1 out_ready = 1'b1;
        step(15);
        check_scn(2, base);

        // FIFO runs dry after the header; payload arrives later
        base = log_q.size();
        push_scn(3, 0);
        step(5);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk($sformatf("s3 gap%0d {valid,busy}", i), {62'd0, out_valid, busy}, 64'd1);
        end
        @(posedge clk);
        #1 push_scn(3, 1);
        step(10);
        check_scn(3, base);
        chk("s3 busy after packet", 64'(busy), 64'd0);

        // enable dropped with the payload word in flight
        out_ready = 1'b0;
        base = log_q.size();
        rd0  = rd_ptr;
        push_scn(4, 0);
        push_scn(4, 1);
        step(2);
        enable = 1'b0;
        step(1);
        out_ready = 1'b1;
        step(8);
        chk("s4 reads while disabled", 64'(rd_ptr - rd0), 64'd2);
        chk("s4 {busy,fifo_en,valid} drained", {61'd0, busy, fifo_en, out_valid}, 64'd0);
        chk("s4 transfers while disabled", 64'(log_q.size() - base), 64'd2);
        enable = 1'b1;
        step(8);
        check_scn(4, base);
        chk("s4 reads after re-enable", 64'(rd_ptr - rd0), 64'd3);

        // Asynchronous reset with two payload words buffered mid-packet
        out_ready = 1'b0;
        base = log_q.size();
        rd0  = rd_ptr;
        push_scn(5, 0);
        step(5);
        chk("s5 reads with buffer full", 64'(rd_ptr - rd0), 64'd2);
        out_ready = 1'b1;
        step(1);
        out_ready = 1'b0;
        step(1);
        chk("s5 pre-reset {busy,valid,sop,data}", {29'd0, busy, out_valid, out_sop, out_data},
            {29'd0, 1'b1, 1'b1, 1'b0, 32'h0000_00F1});
        #2 rst = 1'b1;
        #1;
        chk("s5 async reset {rd_en,valid,sop,eop,busy}",
            {59'd0, fifo_rd_en, out_valid, out_sop, out_eop, busy}, 64'd0);
        chk("s5 async reset out_data", 64'(out_data), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        push_scn(5, 1);
        out_ready = 1'b1;
        step(10);
        check_scn(5, base);

        // Largest length field: 255 payload words, 256-word packet
        base = log_q.size();
        push_word(32'h0000_00FF);
        for (int i = 1; i < 256; i++) push_word(32'h5500_0000 | 32'(i));
        step(300);
        chk("maxN transfer count", 64'(log_q.size() - base), 64'd256);
        bad = 0;
        for (int i = 0; i < 256 && base + i < log_q.size(); i++) begin
            if (log_q[base+i].sop !== (i == 0)) bad++;
            if (log_q[base+i].eop !== (i == 255)) bad++;
            if (log_q[base+i].dat !== ((i == 0) ? 32'h0000_00FF : (32'h5500_0000 | 32'(i)))) bad++;
        end
        chk("maxN framing/data errors", 64'(bad), 64'd0);
        chk("maxN busy after packet", 64'(busy), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
